// File: rtl/pd_pkg.sv
// Shared encodings for the DPLL phase detector and lock tracker.
package pd_pkg;

  typedef enum logic [1:0] {
    LS_UNLOCKED = 2'b00,
    LS_ACQUIRE  = 2'b01,
    LS_LOCKED   = 2'b10,
    LS_HOLD     = 2'b11
  } lock_state_t;

  typedef enum logic [1:0] {
    ZONE_EARLY = 2'b00,
    ZONE_ON    = 2'b01,
    ZONE_LATE  = 2'b10,
    ZONE_OFF   = 2'b11
  } zone_t;

  // On-time edges needed in HOLD before returning to LOCKED.
  localparam int HOLD_RELOCK = 4;

endpackage

// File: rtl/pd_zone_classify.sv
// Combinational margin classifier: signed error -> saturated magnitude, sign and zone.
module pd_zone_classify
  import pd_pkg::*;
#(
  parameter int ERR_W = 16
) (
  input  logic [ERR_W-1:0] i_err,
  input  logic [ERR_W-2:0] i_win_on,
  input  logic [ERR_W-2:0] i_win_near,
  output logic             o_sign,
  output zone_t            o_zone
);

  logic [ERR_W-2:0] w_negated;
  logic [ERR_W-2:0] w_mag;

  assign o_sign    = i_err[ERR_W-1];
  // Only the low bits of the two's complement negation are needed for |e|.
  assign w_negated = ~i_err[ERR_W-2:0] + 1'b1;

  always_comb begin
    w_mag = i_err[ERR_W-2:0];
    if (o_sign) begin
      // The most negative value has no positive twin, so it saturates.
      w_mag = (i_err[ERR_W-2:0] == '0) ? '1 : w_negated;
    end

    if (w_mag < i_win_on) begin
      o_zone = ZONE_ON;
    end else if (w_mag < i_win_near) begin
      o_zone = o_sign ? ZONE_EARLY : ZONE_LATE;
    end else begin
      o_zone = ZONE_OFF;
    end
  end

endmodule

// File: rtl/phase_detector_lock.sv
// Phase detector with margin zones, per-cell missing/extra edge tracking and a lock FSM.
module phase_detector_lock
  import pd_pkg::*;
#(
  parameter int PHASE_W    = 32,
  parameter int ERR_W      = 16,
  parameter int MISS_W     = 4,
  parameter int MISS_LIMIT = 3,
  parameter int LOCK_COUNT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               mode_bb,
  input  logic [ERR_W-2:0]   win_on,
  input  logic [ERR_W-2:0]   win_near,
  input  logic               edge_detected,
  input  logic               bit_tick,
  input  logic [PHASE_W-1:0] nco_phase,
  output logic [ERR_W-1:0]   phase_error,
  output logic               early,
  output logic               late,
  output logic               error_valid,
  output logic [1:0]         margin_zone,
  output logic               missing_pulse,
  output logic               extra_edge,
  output logic [MISS_W-1:0]  consecutive_missing,
  output logic [1:0]         lock_state,
  output logic               locked
);

  localparam int RUN_W     = $clog2(LOCK_COUNT + 1);
  localparam int SAT_MAX   = (1 << MISS_W) - 1;
  localparam int HOLD_LOSS = (2 * MISS_LIMIT > SAT_MAX) ? SAT_MAX : 2 * MISS_LIMIT;

  logic [ERR_W-1:0]  r_phase_error;
  zone_t             r_zone;
  logic              r_error_valid;
  logic              r_early;
  logic              r_late;
  logic              r_missing;
  logic              r_extra;
  logic              r_seen;
  logic [MISS_W-1:0] r_cm;
  lock_state_t       r_state;
  logic              r_locked;
  logic [RUN_W-1:0]  r_run;

  logic              w_edge;
  logic              w_tick;
  logic [ERR_W-1:0]  w_err;
  logic              w_sign;
  zone_t             w_zone;
  logic              w_on;
  logic              w_off;
  logic              w_missing;
  logic [MISS_W-1:0] w_cm_next;
  logic              w_miss_event;
  logic              w_hold_loss;
  logic [RUN_W-1:0]  w_run_inc;

  assign w_edge = enable & edge_detected;
  assign w_tick = enable & bit_tick;
  assign w_err  = nco_phase[PHASE_W-1 -: ERR_W];

  if (PHASE_W > ERR_W) begin : g_phase_lsbs
    logic w_unused_lsbs;
    assign w_unused_lsbs = ^nco_phase[PHASE_W-ERR_W-1:0];
  end

  pd_zone_classify #(.ERR_W(ERR_W)) u_classify (
    .i_err      (w_err),
    .i_win_on   (win_on),
    .i_win_near (win_near),
    .o_sign     (w_sign),
    .o_zone     (w_zone)
  );

  assign w_on  = w_edge && (w_zone == ZONE_ON);
  assign w_off = w_edge && (w_zone == ZONE_OFF);

  // An edge coincident with the tick belongs to the cell that is closing.
  assign w_missing = w_tick & ~(r_seen | w_edge);

  always_comb begin
    w_cm_next = r_cm;
    if (w_tick) begin
      if (w_missing) begin
        w_cm_next = (r_cm == '1) ? r_cm : r_cm + 1'b1;
      end else begin
        w_cm_next = '0;
      end
    end
  end

  assign w_miss_event = w_missing && (w_cm_next == MISS_W'(MISS_LIMIT));
  assign w_hold_loss  = w_missing && (w_cm_next == MISS_W'(HOLD_LOSS));
  assign w_run_inc    = (r_run == RUN_W'(LOCK_COUNT)) ? r_run : r_run + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase_error <= '0;
      r_zone        <= ZONE_ON;
      r_error_valid <= 1'b0;
      r_early       <= 1'b0;
      r_late        <= 1'b0;
      r_missing     <= 1'b0;
      r_extra       <= 1'b0;
      r_seen        <= 1'b0;
      r_cm          <= '0;
    end else begin
      r_error_valid <= w_edge;
      r_early       <= w_edge & w_sign;
      r_late        <= w_edge & ~w_sign;
      r_extra       <= w_edge & r_seen;
      r_missing     <= w_missing;
      if (w_edge) begin
        r_phase_error <= mode_bb ? (w_sign ? '1 : ERR_W'(1)) : w_err;
        r_zone        <= w_zone;
      end
      if (!enable) begin
        r_seen <= 1'b0;
        r_cm   <= '0;
      end else begin
        r_cm <= w_cm_next;
        if (w_tick) begin
          r_seen <= 1'b0;
        end else if (w_edge) begin
          r_seen <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      r_state  <= LS_UNLOCKED;
      r_locked <= 1'b0;
      r_run    <= '0;
    end else begin
      if (w_edge) begin
        r_run <= w_on ? w_run_inc : '0;
      end
      unique case (r_state)
        LS_UNLOCKED: begin
          if (w_on) begin
            r_state <= LS_ACQUIRE;
          end
        end
        LS_ACQUIRE: begin
          if (w_off || w_miss_event) begin
            r_state <= LS_UNLOCKED;
            r_run   <= '0;
          end else if (w_on && (w_run_inc == RUN_W'(LOCK_COUNT))) begin
            r_state  <= LS_LOCKED;
            r_locked <= 1'b1;
          end
        end
        LS_LOCKED: begin
          if (w_off || w_miss_event) begin
            r_state <= LS_HOLD;
            r_run   <= '0;
          end
        end
        LS_HOLD: begin
          if (w_off || w_hold_loss) begin
            r_state  <= LS_UNLOCKED;
            r_locked <= 1'b0;
            r_run    <= '0;
          end else if (w_on && (w_run_inc == RUN_W'(HOLD_RELOCK))) begin
            r_state <= LS_LOCKED;
          end
        end
        default: r_state <= LS_UNLOCKED;
      endcase
    end
  end

  assign phase_error         = r_phase_error;
  assign margin_zone         = r_zone;
  assign error_valid         = r_error_valid;
  assign early               = r_early;
  assign late                = r_late;
  assign missing_pulse       = r_missing;
  assign extra_edge          = r_extra;
  assign consecutive_missing = r_cm;
  assign lock_state          = r_state;
  assign locked              = r_locked;

endmodule

// File: tb/tb_phase_detector_lock.sv
// Directed self-checking bench for phase_detector_lock with default parameters.
module tb_phase_detector_lock;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        mode_bb;
  logic [14:0] win_on;
  logic [14:0] win_near;
  logic        edge_detected;
  logic        bit_tick;
  logic [31:0] nco_phase;
  logic [15:0] phase_error;
  logic        early;
  logic        late;
  logic        error_valid;
  logic [1:0]  margin_zone;
  logic        missing_pulse;
  logic        extra_edge;
  logic [3:0]  consecutive_missing;
  logic [1:0]  lock_state;
  logic        locked;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  phase_detector_lock dut (
    .clk                 (clk),
    .reset               (reset),
    .enable              (enable),
    .mode_bb             (mode_bb),
    .win_on              (win_on),
    .win_near            (win_near),
    .edge_detected       (edge_detected),
    .bit_tick            (bit_tick),
    .nco_phase           (nco_phase),
    .phase_error         (phase_error),
    .early               (early),
    .late                (late),
    .error_valid         (error_valid),
    .margin_zone         (margin_zone),
    .missing_pulse       (missing_pulse),
    .extra_edge          (extra_edge),
    .consecutive_missing (consecutive_missing),
    .lock_state          (lock_state),
    .locked              (locked)
  );

  // Drive one cycle of stimulus; outputs are observed 1 ns after the capturing edge.
  task automatic step(input logic e, input logic t, input logic [31:0] ph);
    edge_detected = e;
    bit_tick      = t;
    nco_phase     = ph;
    @(posedge clk);
    #1;
    edge_detected = 1'b0;
    bit_tick      = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b0, 32'h0);
    reset = 1'b0;
  endtask

  task automatic lock_up(input logic [31:0] ph);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, ph);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(1'b1, 1'b1, 32'h3000_0000);
    checks++; if (phase_error !== 16'h0) begin fails++; $display("FAIL reset_pe got %h exp 0000", phase_error); end
    checks++; if (margin_zone !== 2'b01) begin fails++; $display("FAIL reset_zone got %b exp 01", margin_zone); end
    checks++; if (lock_state !== 2'b00 || locked !== 1'b0) begin fails++; $display("FAIL reset_lock got %b/%b exp 00/0", lock_state, locked); end
    checks++; if ({error_valid, early, late, missing_pulse, extra_edge} !== 5'b0 || consecutive_missing !== 4'd0) begin
      fails++; $display("FAIL reset_pulses got %b cm %0d exp 00000 cm 0", {error_valid, early, late, missing_pulse, extra_edge}, consecutive_missing); end
    reset = 1'b0;
  endtask

  task automatic test_proportional();
    do_reset();
    step(1'b1, 1'b0, 32'hFFF0_0000);
    checks++; if ({error_valid, early, late} !== 3'b110 || phase_error !== 16'hFFF0 || margin_zone !== 2'b01) begin
      fails++; $display("FAIL prop_early v/e/l %b pe %h zone %b exp 110 FFF0 01", {error_valid, early, late}, phase_error, margin_zone); end
    step(1'b0, 1'b0, 32'h0);
    checks++; if (error_valid !== 1'b0 || early !== 1'b0 || phase_error !== 16'hFFF0) begin
      fails++; $display("FAIL prop_hold v %b e %b pe %h exp 0 0 FFF0", error_valid, early, phase_error); end
    step(1'b1, 1'b0, 32'h3000_0000);
    checks++; if ({early, late} !== 2'b01 || phase_error !== 16'h3000 || margin_zone !== 2'b10) begin
      fails++; $display("FAIL prop_late e/l %b pe %h zone %b exp 01 3000 10", {early, late}, phase_error, margin_zone); end
    step(1'b1, 1'b0, 32'h8000_0000);
    checks++; if ({early, late} !== 2'b10 || phase_error !== 16'h8000 || margin_zone !== 2'b11) begin
      fails++; $display("FAIL prop_min e/l %b pe %h zone %b exp 10 8000 11", {early, late}, phase_error, margin_zone); end
  endtask

  task automatic test_zone_bounds();
    logic [31:0] ph [5];
    logic [1:0]  zn [5];
    ph = '{32'h1FFF_0000, 32'h2000_0000, 32'hE000_0000, 32'hC001_0000, 32'h4000_0000};
    zn = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, ph[i]);
      checks++; if (margin_zone !== zn[i]) begin fails++; $display("FAIL zone_bound[%0d] got %b exp %b", i, margin_zone, zn[i]); end
    end
    win_on = 15'h0008;
    step(1'b1, 1'b1, 32'h0010_0000);
    checks++; if (margin_zone !== 2'b10) begin fails++; $display("FAIL zone_win_change got %b exp 10", margin_zone); end
    win_on = 15'h2000;
  endtask

  task automatic test_bang_bang();
    do_reset();
    mode_bb = 1'b1;
    step(1'b1, 1'b0, 32'h3000_0000);
    checks++; if (phase_error !== 16'h0001 || late !== 1'b1 || margin_zone !== 2'b10) begin
      fails++; $display("FAIL bb_late pe %h late %b zone %b exp 0001 1 10", phase_error, late, margin_zone); end
    step(1'b1, 1'b0, 32'h8000_0000);
    checks++; if (phase_error !== 16'hFFFF || early !== 1'b1 || margin_zone !== 2'b11) begin
      fails++; $display("FAIL bb_min pe %h early %b zone %b exp FFFF 1 11", phase_error, early, margin_zone); end
    step(1'b1, 1'b0, 32'hFFF0_0000);
    checks++; if (phase_error !== 16'hFFFF || margin_zone !== 2'b01 || extra_edge !== 1'b1) begin
      fails++; $display("FAIL bb_on pe %h zone %b extra %b exp FFFF 01 1", phase_error, margin_zone, extra_edge); end
    mode_bb = 1'b0;
  endtask

  task automatic test_missing();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b1, 32'h0);
      checks++; if (missing_pulse !== 1'b1 || consecutive_missing !== 4'(i)) begin
        fails++; $display("FAIL miss_count[%0d] pulse %b cm %0d exp 1 %0d", i, missing_pulse, consecutive_missing, i); end
    end
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0);
    checks++; if (missing_pulse !== 1'b0 || consecutive_missing !== 4'd0) begin
      fails++; $display("FAIL miss_clear pulse %b cm %0d exp 0 0", missing_pulse, consecutive_missing); end
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 32'h0);
    checks++; if (consecutive_missing !== 4'd15) begin fails++; $display("FAIL miss_sat cm %0d exp 15", consecutive_missing); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    step(1'b1, 1'b1, 32'h0);
    checks++; if (missing_pulse !== 1'b0 || extra_edge !== 1'b0 || error_valid !== 1'b1) begin
      fails++; $display("FAIL same_first miss %b extra %b v %b exp 0 0 1", missing_pulse, extra_edge, error_valid); end
    step(1'b0, 1'b1, 32'h0);
    checks++; if (missing_pulse !== 1'b1 || consecutive_missing !== 4'd1) begin
      fails++; $display("FAIL same_second miss %b cm %0d exp 1 1", missing_pulse, consecutive_missing); end
    step(1'b1, 1'b0, 32'h0);
    checks++; if (extra_edge !== 1'b0) begin fails++; $display("FAIL extra_first got %b exp 0", extra_edge); end
    step(1'b1, 1'b0, 32'h0);
    checks++; if (extra_edge !== 1'b1 || error_valid !== 1'b1) begin fails++; $display("FAIL extra_second extra %b v %b exp 1 1", extra_edge, error_valid); end
    step(1'b1, 1'b1, 32'h0);
    checks++; if (extra_edge !== 1'b1 || missing_pulse !== 1'b0) begin fails++; $display("FAIL extra_closing extra %b miss %b exp 1 0", extra_edge, missing_pulse); end
    step(1'b1, 1'b0, 32'h0);
    checks++; if (extra_edge !== 1'b0) begin fails++; $display("FAIL extra_newcell got %b exp 0", extra_edge); end
  endtask

  task automatic test_lock_fsm();
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b1, 32'h0);
      if (i == 1 || i == 15) begin
        checks++; if (lock_state !== 2'b01 || locked !== 1'b0) begin fails++; $display("FAIL acquire[%0d] got %b/%b exp 01/0", i, lock_state, locked); end
      end
    end
    checks++; if (lock_state !== 2'b10 || locked !== 1'b1) begin fails++; $display("FAIL locked16 got %b/%b exp 10/1", lock_state, locked); end
    step(1'b1, 1'b1, 32'h8000_0000);
    checks++; if (lock_state !== 2'b11 || locked !== 1'b1) begin fails++; $display("FAIL to_hold got %b/%b exp 11/1", lock_state, locked); end
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b1, 32'h0);
      checks++; if (lock_state !== ((i == 4) ? 2'b10 : 2'b11)) begin
        fails++; $display("FAIL relock[%0d] got %b exp %b", i, lock_state, (i == 4) ? 2'b10 : 2'b11); end
    end
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 1'b1, 32'h0);
      checks++; if (lock_state !== ((i < 3) ? 2'b10 : (i < 6) ? 2'b11 : 2'b00) || consecutive_missing !== 4'(i)) begin
        fails++; $display("FAIL miss_fsm[%0d] got %b cm %0d exp %b cm %0d", i, lock_state,
                          consecutive_missing, (i < 3) ? 2'b10 : (i < 6) ? 2'b11 : 2'b00, i); end
    end
    checks++; if (locked !== 1'b0) begin fails++; $display("FAIL unlock_flag got %b exp 0", locked); end
  endtask

  task automatic test_abort();
    do_reset();
    lock_up(32'h0010_0000);
    step(1'b0, 1'b1, 32'h0);
    checks++; if (lock_state !== 2'b10 || consecutive_missing !== 4'd1) begin fails++; $display("FAIL pre_disable got %b cm %0d exp 10 1", lock_state, consecutive_missing); end
    enable = 1'b0;
    step(1'b1, 1'b1, 32'h3000_0000);
    checks++; if (lock_state !== 2'b00 || locked !== 1'b0 || consecutive_missing !== 4'd0) begin
      fails++; $display("FAIL disable_lock got %b/%b cm %0d exp 00/0 0", lock_state, locked, consecutive_missing); end
    checks++; if ({error_valid, missing_pulse, late} !== 3'b000 || phase_error !== 16'h0010 || margin_zone !== 2'b01) begin
      fails++; $display("FAIL disable_hold pulses %b pe %h zone %b exp 000 0010 01", {error_valid, missing_pulse, late}, phase_error, margin_zone); end
    enable = 1'b1;
    lock_up(32'h0);
    checks++; if (lock_state !== 2'b10) begin fails++; $display("FAIL relock_after_enable got %b exp 10", lock_state); end
    reset = 1'b1;
    step(1'b1, 1'b0, 32'h3000_0000);
    checks++; if (lock_state !== 2'b00 || locked !== 1'b0 || error_valid !== 1'b0 || phase_error !== 16'h0) begin
      fails++; $display("FAIL reset_abort got %b/%b v %b pe %h exp 00/0 0 0000", lock_state, locked, error_valid, phase_error); end
    reset = 1'b0;
    step(1'b1, 1'b1, 32'h0);
    checks++; if (lock_state !== 2'b01 || error_valid !== 1'b1) begin fails++; $display("FAIL post_reset_edge got %b v %b exp 01 1", lock_state, error_valid); end
  endtask

  initial begin
    reset         = 1'b1;
    enable        = 1'b1;
    mode_bb       = 1'b0;
    win_on        = 15'h2000;
    win_near      = 15'h4000;
    edge_detected = 1'b0;
    bit_tick      = 1'b0;
    nco_phase     = 32'h0;
    #1;
    test_reset();
    test_proportional();
    test_zone_bounds();
    test_bang_bang();
    test_missing();
    test_same_cycle();
    test_lock_fsm();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/phase_detector_lock.md
# phase_detector_lock

Parametrised successor to the DPLL phase detector. It samples the NCO phase on every flux edge and produces a signed proportional error, or a bang-bang error when the mode input selects it. It also classifies each edge into a margin zone, detects missing and extra flux pulses per bit cell, and runs a lock-state machine for the data separator's loop filter and status registers. It sits between the edge detector and the loop filter; lock status is exported to the controller.

## Interface
Parameters:
- PHASE_W, 32, NCO phase accumulator width.
- ERR_W, 16, phase error width (≤ PHASE_W).
- MISS_W, 4, width of the consecutive-missing counter.
- MISS_LIMIT, 3, consecutive missing cells that count as a loss event.
- LOCK_COUNT, 16, consecutive on-time edges needed to declare lock (≥ 4).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  block enable; when low, forces the FSM to UNLOCKED and suppresses all pulses.
- mode_bb  in  1  0 = proportional error, 1 = bang-bang error.
- win_on  in  ERR_W-1  on-time half-window, as an unsigned magnitude.
- win_near  in  ERR_W-1  near half-window, as an unsigned magnitude (≥ win_on).
- edge_detected  in  1  one-cycle flux edge pulse.
- bit_tick  in  1  one-cycle NCO wrap (bit boundary) pulse.
- nco_phase  in  PHASE_W  current NCO phase.
- phase_error  out  ERR_W  signed error.
- early  out  1  one-cycle pulse, edge before the boundary.
- late  out  1  one-cycle pulse, edge at or after the boundary.
- error_valid  out  1  one-cycle pulse, outputs updated.
- margin_zone  out  2  00 = early, 01 = on-time, 10 = late, 11 = way off.
- missing_pulse  out  1  one-cycle pulse, no edge in the closed cell.
- extra_edge  out  1  one-cycle pulse, second or later edge in the same cell.
- consecutive_missing  out  MISS_W  saturating count of missing cells.
- lock_state  out  2  00 = UNLOCKED, 01 = ACQUIRE, 10 = LOCKED, 11 = HOLD.
- locked  out  1  high in LOCKED or HOLD.

## Operation
- Raw error e is nco_phase[PHASE_W-1 -: ERR_W], read as two's complement.
  - e ≥ 0: the edge is late.
  - e < 0: the edge is early.
- Magnitude m = |e|. The value -2^(ERR_W-1) saturates to 2^(ERR_W-1)-1.
- Zone assignment:
  - m < win_on → 01.
  - Otherwise, m < win_near → 00 if e < 0, 10 if e ≥ 0.
  - Otherwise → 11.
- Error output:
  - mode_bb = 0: phase_error = e.
  - mode_bb = 1: phase_error = +1 if e ≥ 0, else -1, sign-extended to ERR_W.
- early and late pulse on every valid edge in both modes. Exactly one of them is high per error_valid.
- Cell tracking uses a seen flag and an extra-edge condition.
  - An edge with seen = 1 asserts extra_edge. It still produces a normal error_valid.
  - On bit_tick with seen = 0: missing_pulse is asserted and consecutive_missing increments, saturating at 2^MISS_W-1.
  - On bit_tick with seen = 1: consecutive_missing clears. seen is then cleared.
- Simultaneous edge_detected and bit_tick: the edge belongs to the closing cell.
  - The closing cell counts as seen; no missing_pulse.
  - The new cell starts with seen = 0.
  - extra_edge is evaluated against the closing cell's seen.
- Lock FSM. Counter run counts consecutive on-time edges and resets on any edge outside zone 01. "Miss event" means consecutive_missing reaches MISS_LIMIT.
  - UNLOCKED → ACQUIRE on an on-time edge (run = 1).
  - ACQUIRE → LOCKED when run reaches LOCK_COUNT.
  - ACQUIRE → UNLOCKED on a zone-11 edge or a miss event.
  - LOCKED → HOLD on a zone-11 edge or a miss event. Zone 00/10 edges only reset run.
  - HOLD → LOCKED after 4 consecutive on-time edges.
  - HOLD → UNLOCKED on a zone-11 edge, or when consecutive_missing reaches 2×MISS_LIMIT (saturated).
- enable low:
  - FSM goes to UNLOCKED; run, seen and consecutive_missing clear.
  - No pulses are generated; phase_error and margin_zone hold.
- Bit-cell tracking (seen, cell closing, missing/extra detection) runs in both modes.

## Timing
- All outputs are registered.
- Inputs sampled on edge N appear on edge N+1: a one-cycle latency for error_valid, early, late, extra_edge, phase_error, margin_zone and missing_pulse.
- lock_state and consecutive_missing update in the same cycle as the pulse that causes them.
- All pulses are exactly one cycle wide. Back-to-back edges on consecutive cycles each produce a pulse.
- Reset values:
  - phase_error = 0, margin_zone = 01, lock_state = 00, consecutive_missing = 0.
  - All pulses 0; locked = 0; run = 0; seen = 0.
- Reset mid-operation aborts lock immediately. The next cycle is UNLOCKED with no pulses.
- win_on and win_near are sampled combinationally on the edge cycle. Changing them mid-stream affects the next edge only.

## Structure
- Shared package pd_pkg holds:
  - lock-state encodings LS_UNLOCKED/LS_ACQUIRE/LS_LOCKED/LS_HOLD;
  - zone encodings ZONE_EARLY/ZONE_ON/ZONE_LATE/ZONE_OFF;
  - the HOLD re-lock constant (4).
- One sub-module, pd_zone_classify (combinational: e → m, zone, sign). The top level keeps the cell tracker, the FSM and the output registers.

## Test plan
- PHASE_W = 32, ERR_W = 16, win_on = 0x2000, win_near = 0x4000, nco_phase = 0xFFF00000 → phase_error = 0xFFF0 (-16), zone 01, early = 1, one cycle after the edge.
- nco_phase = 0x30000000 → zone 10, late = 1. nco_phase = 0x80000000 → zone 11, m saturates to 0x7FFF. Repeat with mode_bb = 1 → phase_error = 0x0001 / 0xFFFF.
- Five bit_ticks with no edges, MISS_W = 4 → five missing_pulse, consecutive_missing = 1..5. An edge then a tick → count = 0.
- Edge and bit_tick in the same cycle, then a second tick → no missing_pulse on the first tick, missing_pulse on the second. Two edges in one cell → extra_edge on the second edge.
- 16 on-time edges, one per cell → ACQUIRE after the first, LOCKED on the 16th. A zone-11 edge → HOLD. 4 on-time edges → LOCKED. 3 empty cells → HOLD; 3 more → UNLOCKED.
- Reset asserted, or enable deasserted, while LOCKED → lock_state = 00, locked = 0, consecutive_missing = 0 on the next edge.
